// File: rtl/crypto1_pkg.sv
// Shared definitions for the crypto1 subkey datapath: ring phase encoding
// and the common subkey width.
package crypto1_pkg;

    localparam int SUBKEY_W = 24;

    typedef enum logic {
        PH_FILL  = 1'b0,
        PH_CYCLE = 1'b1
    } phase_e;

endpackage

// File: rtl/ring_buf.sv
// Subkey ring: fills once from an upstream FIFO, then replays the stored
// entries in order, wrapping forever until reset.
module ring_buf
    import crypto1_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = SUBKEY_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] FIFO_RDDATA,
    output logic             FIFO_RDEN,
    input  logic             FIFO_RDEMPTY,
    input  logic             FIFO_DONE,
    input  logic             RDEN,
    output logic [WIDTH-1:0] RDDATA,
    output logic             FULL,
    output logic             DONE,
    output logic             END
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] ZERO_C  = CW'(0);
    localparam logic [AW-1:0] RP_ZERO = AW'(0);
    localparam logic [AW-1:0] RP_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    phase_e           phase_q,    phase_d;
    logic [CW-1:0]    count_q,    count_d;
    logic [AW-1:0]    rptr_q,     rptr_d;
    logic             inflight_q, inflight_d;
    logic             full_q,     full_d;
    logic             done_q,     done_d;
    logic             end_q,      end_d;
    logic [WIDTH-1:0] rddata_q,   rddata_d;

    logic          pop_s;
    logic          wr_s;
    logic          rd_s;
    logic          last_s;
    logic          fill_end_s;
    logic [CW-1:0] pending_s;

    // Pops are combinational so the FIFO sees the request in the same cycle
    // its empty flag is valid; a pop already in flight counts toward DEPTH.
    assign pending_s  = count_q + (inflight_q ? ONE_C : ZERO_C);
    assign pop_s      = (phase_q == PH_FILL) && !RESET && !FIFO_RDEMPTY && (pending_s < DEPTH_C);
    assign wr_s       = (phase_q == PH_FILL) && inflight_q;
    assign fill_end_s = (phase_q == PH_FILL) &&
                        ((count_q == DEPTH_C) || (FIFO_DONE && FIFO_RDEMPTY && !inflight_q));
    assign rd_s       = (phase_q == PH_CYCLE) && RDEN && (count_q != ZERO_C);
    assign last_s     = (CW'(rptr_q) == (count_q - ONE_C));

    assign FIFO_RDEN = pop_s;
    assign RDDATA    = rddata_q;
    assign FULL      = full_q;
    assign DONE      = done_q;
    assign END       = end_q;

    // Next-state logic for the fill/cycle phases and the output registers.
    always_comb begin
        phase_d    = phase_q;
        count_d    = count_q;
        rptr_d     = rptr_q;
        inflight_d = 1'b0;
        full_d     = full_q;
        done_d     = done_q;
        end_d      = end_q;
        rddata_d   = rddata_q;
        case (phase_q)
            PH_FILL: begin
                inflight_d = pop_s;
                if (wr_s) begin
                    count_d = count_q + ONE_C;
                end else begin
                    count_d = count_q;
                end
                // An empty ring still reports END so the consumer sees a
                // complete (zero-length) pass.
                if (fill_end_s) begin
                    phase_d = PH_CYCLE;
                    full_d  = 1'b1;
                    done_d  = FIFO_DONE && FIFO_RDEMPTY;
                    end_d   = (count_q == ZERO_C);
                end else begin
                    phase_d = PH_FILL;
                end
            end
            PH_CYCLE: begin
                if (rd_s) begin
                    rddata_d = mem_q[rptr_q];
                    end_d    = last_s;
                    rptr_d   = last_s ? RP_ZERO : (rptr_q + RP_ONE);
                end else begin
                    rptr_d   = rptr_q;
                end
            end
            default: begin
                phase_d = PH_FILL;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            phase_q    <= PH_FILL;
            count_q    <= ZERO_C;
            rptr_q     <= RP_ZERO;
            inflight_q <= 1'b0;
            full_q     <= 1'b0;
            done_q     <= 1'b0;
            end_q      <= 1'b0;
            rddata_q   <= {WIDTH{1'b0}};
        end else begin
            phase_q    <= phase_d;
            count_q    <= count_d;
            rptr_q     <= rptr_d;
            inflight_q <= inflight_d;
            full_q     <= full_d;
            done_q     <= done_d;
            end_q      <= end_d;
            rddata_q   <= rddata_d;
        end
    end

    // Storage array: no reset so it maps onto distributed RAM.
    always_ff @(posedge CLK) begin
        if (wr_s && !RESET) begin
            mem_q[count_q[AW-1:0]] <= FIFO_RDDATA;
        end
    end

endmodule

// File: tb/tb_ring_buf.sv
// Randomized scoreboard bench for ring_buf (DEPTH=4, WIDTH=24).
module tb_ring_buf;

    localparam int DEPTH = 4;
    localparam int WIDTH = 24;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } exp_t;

    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic [WIDTH-1:0] fifo_rddata = '0;
    logic             fifo_rden;
    logic             fifo_empty = 1'b1;
    logic             fifo_done = 1'b0;
    logic             rden = 1'b0;
    logic [WIDTH-1:0] rddata;
    logic             full;
    logic             done;
    logic             end_o;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] src[$];
    logic [WIDTH-1:0] stream[$];
    logic [WIDTH-1:0] ring[$];

    int   checks = 0;
    int   errors = 0;
    int   pops = 0;
    int   ring_n = 0;
    bit   gate = 1'b0;
    bit   tog = 1'b0;
    bit   pend = 1'b0;
    bit   has_cur = 1'b0;
    exp_t cur;

    ring_buf #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .FIFO_RDDATA (fifo_rddata),
        .FIFO_RDEN   (fifo_rden),
        .FIFO_RDEMPTY(fifo_empty),
        .FIFO_DONE   (fifo_done),
        .RDEN        (rden),
        .RDDATA      (rddata),
        .FULL        (full),
        .DONE        (done),
        .END         (end_o)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: a read accepted at one edge is checked from the next negedge
    // on, and the held value is re-checked every cycle until the next read.
    always @(negedge CLK) begin
        if (RESET) begin
            pend    = 1'b0;
            has_cur = 1'b0;
        end else begin
            if (pend) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_underflow: got a read, expected none at %0t", $time);
                end else begin
                    cur     = exp_q.pop_front();
                    has_cur = 1'b1;
                end
            end
            if (has_cur) begin
                chk("rddata", {8'd0, rddata}, {8'd0, cur.data});
                chk("end", {31'd0, end_o}, {31'd0, cur.last});
            end
            pend = rden && full && (ring_n > 0);
        end
    end

    // One clock: upstream FIFO model pops on FIFO_RDEN and presents data
    // during the following cycle.
    task automatic step();
        bit pop_now;
        @(negedge CLK);
        pop_now = fifo_rden;
        chk("fifo_rden_illegal", {31'd0, fifo_rden && (fifo_empty || RESET)}, 32'd0);
        @(posedge CLK);
        #1;
        if (pop_now && src.size() > 0) begin
            fifo_rddata = src.pop_front();
            pops++;
        end else begin
            fifo_rddata = WIDTH'($urandom);
        end
        if (tog) gate = ~gate;
        fifo_empty = (src.size() == 0) || gate;
    endtask

    task automatic do_reset(input int cyc);
        RESET = 1'b1;
        repeat (cyc) step();
        exp_q.delete();
        ring_n = 0;
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_end", {31'd0, end_o}, 32'd0);
        chk("rst_rddata", {8'd0, rddata}, 32'd0);
        chk("rst_fifo_rden", {31'd0, fifo_rden}, 32'd0);
    endtask

    task automatic run_block(input bit done_f, input bit tg, input int nreads, input bit hold);
        int n;
        int cyc;
        int k;
        int got;
        bit exp_done;
        exp_t e;
        src = stream;
        n = (stream.size() < DEPTH) ? stream.size() : DEPTH;
        ring.delete();
        for (int i = 0; i < n; i++) ring.push_back(stream[i]);
        exp_done   = done_f && (stream.size() <= DEPTH);
        fifo_done  = done_f;
        tog        = tg;
        gate       = 1'b0;
        rden       = 1'b0;
        fifo_empty = (src.size() == 0);
        do_reset(2);
        pops   = 0;
        ring_n = n;
        RESET  = 1'b0;
        cyc = 0;
        while (!full && cyc < 100) begin
            step();
            cyc++;
        end
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_done", {31'd0, done}, {31'd0, exp_done});
        chk("fill_rddata", {8'd0, rddata}, 32'd0);
        chk("fill_end", {31'd0, end_o}, {31'd0, n == 0});
        k = 0;
        got = 0;
        cyc = 0;
        while (got < nreads && cyc < 1000) begin
            if (hold || $urandom_range(0, 2) != 0) begin
                rden = 1'b1;
                if (n > 0) begin
                    e.data = ring[k % n];
                    e.last = ((k % n) == n - 1);
                    exp_q.push_back(e);
                    k++;
                end
                got++;
            end else begin
                rden = 1'b0;
            end
            step();
            cyc++;
        end
        rden = 1'b0;
        step();
        step();
        chk("scoreboard_drain", exp_q.size(), 32'd0);
        chk("pop_count", pops, n);
        chk("full_hold", {31'd0, full}, 32'd1);
        chk("done_hold", {31'd0, done}, {31'd0, exp_done});
        if (n == 0) begin
            chk("zero_rddata", {8'd0, rddata}, 32'd0);
            chk("zero_end", {31'd0, end_o}, 32'd1);
        end
    endtask

    initial begin
        int len;
        bit df;
        // 1..6 without done: exactly four pops, ring replays 1..4.
        stream = '{24'h1, 24'h2, 24'h3, 24'h4, 24'h5, 24'h6};
        run_block(1'b0, 1'b0, 8, 1'b0);
        // Reset while cycling, then a fresh block must show no stale data.
        stream = '{24'h20, 24'h21, 24'h22, 24'h23};
        run_block(1'b0, 1'b0, 6, 1'b0);
        // Partial fill ended by done.
        stream = '{24'hA, 24'hB};
        run_block(1'b1, 1'b0, 4, 1'b0);
        // Zero entries.
        stream.delete();
        run_block(1'b1, 1'b0, 3, 1'b0);
        // Empty flag toggling during the fill.
        stream = '{24'h10, 24'h11, 24'h12, 24'h13};
        run_block(1'b0, 1'b1, 5, 1'b0);
        // Abandon a fill with a pop in flight, then hold RDEN through wraps.
        stream = '{24'h30, 24'h31, 24'h32, 24'h33, 24'h34, 24'h35};
        src = stream;
        fifo_done  = 1'b0;
        tog        = 1'b0;
        fifo_empty = 1'b0;
        RESET      = 1'b0;
        repeat (3) step();
        stream = '{24'h1, 24'h2, 24'h3, 24'h4};
        run_block(1'b0, 1'b0, 10, 1'b1);
        // Randomized blocks.
        for (int r = 0; r < 8; r++) begin
            len = $urandom_range(0, 7);
            df  = (len < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
            stream.delete();
            for (int i = 0; i < len; i++) stream.push_back(WIDTH'($urandom));
            run_block(df, df ? 1'b0 : 1'($urandom_range(0, 1)),
                      $urandom_range(1, 10), 1'($urandom_range(0, 1)));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
